// File: rtl/entrada_debounce.sv
// -----------------------------------------------------------------------------
// entrada_debounce
//
// Input peripheral that serves the processor's IN instruction. The user selects
// a word on the board switches and then presses the confirm button. While the
// processor waits, the block holds the processor with "stall". When the button
// press is accepted, the switch word is registered into "dado" and "pronto"
// pulses for one cycle.
//
// Input conditioning:
//   * botao_n and every interruptores bit pass through a 2-flop synchronizer.
//   * The button has a debounce counter. A level is accepted only after it has
//     stayed stable for DEBOUNCE_CYCLES consecutive cycles.
//   * Optional feature, enabled by the macro SWITCH_DEBOUNCE_EN: each switch
//     bit gets its own debounce counter, and the capture takes the debounced
//     word. Without the macro, the capture takes the synchronized word, and no
//     switch counters are built.
//
// Timing: a change on botao_n reaches the debounced level 2 + DEBOUNCE_CYCLES
// rising edges after it is applied. That is 2 edges for the synchronizer plus
// the debounce count. The accept/capture happens on that same edge.
// -----------------------------------------------------------------------------
module entrada_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             botao_n,
  input  logic [WIDTH-1:0] interruptores,
  input  logic             req,
  output logic [WIDTH-1:0] dado,
  output logic             pronto,
  output logic             stall
);

  // Counter sizing. A counter must hold DEBOUNCE_CYCLES-1 and needs at least one bit.
  localparam int              CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Shared debounce step, used for the button and for each switch bit.
  //
  // While the synchronized level matches the accepted level, the counter sits
  // at its reload value. While the two differ, the counter runs down. The new
  // level is accepted on the cycle the counter is found at zero. A bounce back
  // to the accepted level reloads the counter, so the count starts again from
  // the top.
  //
  // The function returns {accepted_level, counter}.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W:0] deb_next(input logic             sync_lvl,
                                              input logic             deb_lvl,
                                              input logic [CNT_W-1:0] cnt);
    logic [CNT_W:0] nxt;
    if (sync_lvl == deb_lvl) begin
      nxt = {deb_lvl, CNT_RELOAD};
    end else if (cnt == CNT_ZERO) begin
      nxt = {sync_lvl, CNT_RELOAD};
    end else begin
      nxt = {deb_lvl, cnt - CNT_ONE};
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic             btn_meta_r;
  logic             btn_sync_r;
  logic [WIDTH-1:0] sw_meta_r;
  logic [WIDTH-1:0] sw_sync_r;

  // Two-flop synchronizers; reset to "button released" (1) and switches 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta_r <= 1'b1;
      btn_sync_r <= 1'b1;
      sw_meta_r  <= {WIDTH{1'b0}};
      sw_sync_r  <= {WIDTH{1'b0}};
    end else begin
      btn_meta_r <= botao_n;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= interruptores;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Button debounce (active-low: 1 = released, 0 = pressed)
  // ---------------------------------------------------------------------------
  logic             btn_deb_n_r;
  logic [CNT_W-1:0] btn_cnt_r;
  logic             btn_press_s;

  // Debounced button level and its stability counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_deb_n_r <= 1'b1;
      btn_cnt_r   <= CNT_RELOAD;
    end else begin
      {btn_deb_n_r, btn_cnt_r} <= deb_next(btn_sync_r, btn_deb_n_r, btn_cnt_r);
    end
  end

  // A press is the edge on which the debounced level flips from released to
  // pressed. It is detected combinationally, so the FSM reacts on the same
  // edge that updates the debounced level.
  always_comb begin
    btn_press_s = 1'b0;
    if ((btn_sync_r != btn_deb_n_r) && (btn_cnt_r == CNT_ZERO) && !btn_sync_r) begin
      btn_press_s = 1'b1;
    end else begin
      btn_press_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Switch word offered to the capture register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] capture_word_s;

`ifdef SWITCH_DEBOUNCE_EN
  logic [WIDTH-1:0] sw_deb_r;
  logic [CNT_W-1:0] sw_cnt_r [WIDTH];

  // Per-bit debounce of the synchronized switches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_deb_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        sw_cnt_r[i] <= CNT_RELOAD;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        {sw_deb_r[i], sw_cnt_r[i]} <= deb_next(sw_sync_r[i], sw_deb_r[i], sw_cnt_r[i]);
      end
    end
  end

  assign capture_word_s = sw_deb_r;
`else
  assign capture_word_s = sw_sync_r;
`endif

  // ---------------------------------------------------------------------------
  // Transfer FSM
  //   OCIOSO  : idle. A request moves to ESPERA. A press seen here is ignored.
  //   ESPERA  : processor stalled. A fresh press captures the word.
  //   ENTREGA : the one cycle in which pronto is high.
  //   SOLTA   : wait for the button to be released before re-arming.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2,
    SOLTA   = 2'd3
  } estado_t;

  estado_t state_r;
  estado_t state_s;
  logic    capture_s;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= OCIOSO;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and capture enable.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (req) begin
          state_s = ESPERA;
        end else begin
          state_s = OCIOSO;
        end
      end
      ESPERA: begin
        // If the request is withdrawn, that wins over a press on the same edge.
        if (!req) begin
          state_s = OCIOSO;
        end else if (btn_press_s) begin
          state_s   = ENTREGA;
          capture_s = 1'b1;
        end else begin
          state_s = ESPERA;
        end
      end
      ENTREGA: begin
        state_s = SOLTA;
      end
      SOLTA: begin
        if (btn_deb_n_r) begin
          state_s = OCIOSO;
        end else begin
          state_s = SOLTA;
        end
      end
      default: begin
        state_s = OCIOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they line up with it.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dado_r;
  logic             pronto_r;
  logic             stall_r;

  // Output registers. dado holds its value until the next capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_r   <= {WIDTH{1'b0}};
      pronto_r <= 1'b0;
      stall_r  <= 1'b0;
    end else begin
      pronto_r <= (state_s == ENTREGA);
      stall_r  <= (state_s == ESPERA);
      if (capture_s) begin
        dado_r <= capture_word_s;
      end else begin
        dado_r <= dado_r;
      end
    end
  end

  assign dado   = dado_r;
  assign pronto = pronto_r;
  assign stall  = stall_r;

endmodule

// File: tb/tb_entrada_debounce.sv
// -----------------------------------------------------------------------------
// Directed testbench for entrada_debounce, run with DEBOUNCE_CYCLES=4 and
// WIDTH=16. A press applied just after an edge is accepted on the 6th
// following edge. The outputs are sampled 1 time unit after each rising edge.
// The switch-debounce scenario is built only when SWITCH_DEBOUNCE_EN is defined.
// -----------------------------------------------------------------------------
module tb_entrada_debounce;

  localparam int W  = 16;
  localparam int DC = 4;

  logic         clock         = 1'b0;
  logic         reset         = 1'b0;
  logic         botao_n       = 1'b1;
  logic [W-1:0] interruptores = 16'h0000;
  logic         req           = 1'b0;
  logic [W-1:0] dado;
  logic         pronto;
  logic         stall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  entrada_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clock         (clock),
    .reset         (reset),
    .botao_n       (botao_n),
    .interruptores (interruptores),
    .req           (req),
    .dado          (dado),
    .pronto        (pronto),
    .stall         (stall)
  );

  // Check pronto and stall against their expected values.
  task automatic check_ps(input logic ep, input logic es, input string tag);
    n_vec++;
    assert (pronto === ep) else begin
      n_err++;
      $error("FAIL %s: pronto observed %0b expected %0b", tag, pronto, ep);
    end
    n_vec++;
    assert (stall === es) else begin
      n_err++;
      $error("FAIL %s: stall observed %0b expected %0b", tag, stall, es);
    end
  endtask

  // Check dado against its expected value.
  task automatic check_dado(input logic [W-1:0] exp, input string tag);
    n_vec++;
    assert (dado === exp) else begin
      n_err++;
      $error("FAIL %s: dado observed %h expected %h", tag, dado, exp);
    end
  endtask

  // Advance one clock, then check pronto and stall.
  task automatic step(input logic ep, input logic es, input string tag);
    @(posedge clock);
    #1;
    check_ps(ep, es, tag);
  endtask

  // Run n cycles with constant expected pronto and stall.
  task automatic idle(input int n, input logic ep, input logic es, input string tag);
    for (int i = 0; i < n; i++) begin
      step(ep, es, tag);
    end
  endtask

  // Starting in ESPERA: press the button, expect stall for 5 edges, then
  // pronto with the captured word on the 6th edge.
  task automatic press_capture(input logic [W-1:0] exp, input string tag);
    botao_n = 1'b0;
    idle(DC + 1, 1'b0, 1'b1, tag);
    step(1'b1, 1'b0, tag);
    check_dado(exp, tag);
  endtask

  initial begin
    // Reset. An explicit rising edge on reset triggers the async clear.
    #2 reset = 1'b1;
    #1;
    check_ps(1'b0, 1'b0, "rst");
    check_dado(16'h0000, "rst_dado");
    idle(2, 1'b0, 1'b0, "rst_hold");
    reset = 1'b0;
    idle(4, 1'b0, 1'b0, "idle0");

    // Scenario 1: clean press held 10 cycles.
    interruptores = 16'hA5C3;
    req = 1'b1;
    step(1'b0, 1'b1, "s1_req");
    press_capture(16'hA5C3, "s1");
    req = 1'b0;
    step(1'b0, 1'b0, "s1_solta");
    idle(3, 1'b0, 1'b0, "s1_held");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s1_rel");
    check_dado(16'hA5C3, "s1_hold_dado");

    // Scenario 2: bounce 1/0/1/0, then a stable press.
    interruptores = 16'h5A3C;
    req = 1'b1;
    step(1'b0, 1'b1, "s2_req");
    botao_n = 1'b0; step(1'b0, 1'b1, "s2_bounce");
    botao_n = 1'b1; step(1'b0, 1'b1, "s2_bounce");
    botao_n = 1'b0; step(1'b0, 1'b1, "s2_bounce");
    botao_n = 1'b1; step(1'b0, 1'b1, "s2_bounce");
    press_capture(16'h5A3C, "s2");
    req = 1'b0;
    step(1'b0, 1'b0, "s2_solta");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s2_rel");

    // Scenario 3: button held through pronto, req stays high.
    interruptores = 16'h1234;
    req = 1'b1;
    step(1'b0, 1'b1, "s3_req");
    press_capture(16'h1234, "s3_first");
    interruptores = 16'h0001;
    idle(10, 1'b0, 1'b0, "s3_held");
    check_dado(16'h1234, "s3_held_dado");
    botao_n = 1'b1;
    idle(7, 1'b0, 1'b0, "s3_rel");
    step(1'b0, 1'b1, "s3_rearm");
    press_capture(16'h0001, "s3_second");
    req = 1'b0;
    step(1'b0, 1'b0, "s3_solta");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s3_end");

    // Scenario 4: reset in ESPERA while the button is pressed.
    interruptores = 16'hBEEF;
    req = 1'b1;
    step(1'b0, 1'b1, "s4_req");
    botao_n = 1'b0;
    idle(3, 1'b0, 1'b1, "s4_pre");
    reset = 1'b1;
    #1;
    check_ps(1'b0, 1'b0, "s4_rst_now");
    check_dado(16'h0000, "s4_rst_dado");
    botao_n = 1'b1;
    idle(2, 1'b0, 1'b0, "s4_rst_hold");
    reset = 1'b0;
    idle(9, 1'b0, 1'b1, "s4_wait");
    check_dado(16'h0000, "s4_no_cap");
    press_capture(16'hBEEF, "s4_fresh");
    req = 1'b0;
    step(1'b0, 1'b0, "s4_solta");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s4_end");

    // Scenario 5: button pressed before req rises.
    interruptores = 16'h0F0F;
    botao_n = 1'b0;
    idle(8, 1'b0, 1'b0, "s5_pre");
    req = 1'b1;
    step(1'b0, 1'b1, "s5_req");
    idle(8, 1'b0, 1'b1, "s5_held");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b1, "s5_rel");
    press_capture(16'h0F0F, "s5_fresh");
    req = 1'b0;
    step(1'b0, 1'b0, "s5_solta");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s5_end");

    // req rise and press edge on the same edge in OCIOSO: the press is ignored.
    interruptores = 16'h7777;
    botao_n = 1'b0;
    idle(DC + 1, 1'b0, 1'b0, "s7_pre");
    req = 1'b1;
    step(1'b0, 1'b1, "s7_same");
    idle(6, 1'b0, 1'b1, "s7_after");
    check_dado(16'h0F0F, "s7_dado");
    req = 1'b0;
    step(1'b0, 1'b0, "s7_drop");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s7_end");

`ifdef SWITCH_DEBOUNCE_EN
    // Scenario 6: bit 0 toggles every cycle during the capture window.
    interruptores = 16'h00F1;
    req = 1'b1;
    step(1'b0, 1'b1, "s6_req");
    idle(6, 1'b0, 1'b1, "s6_settle");
    botao_n = 1'b0;
    for (int k = 0; k < DC + 1; k++) begin
      interruptores[0] = ~interruptores[0];
      step(1'b0, 1'b1, "s6_toggle");
    end
    interruptores[0] = ~interruptores[0];
    step(1'b1, 1'b0, "s6_pronto");
    check_dado(16'h00F1, "s6_dado");
    req = 1'b0;
    step(1'b0, 1'b0, "s6_solta");
    botao_n = 1'b1;
    idle(8, 1'b0, 1'b0, "s6_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
